// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: shared types and constants for the modulus-N up/down
// counter family.
//   state_t      - one-shot control FSM states (IDLE, RUN, DONE)
//   MODE_*       - values of the mode input
//   DIR_*        - values of the up_dn input
//   cnt_width()  - width of the count for a given modulus
package mod_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Number of bits needed to hold 0..mod-1 (mod >= 2).
  function automatic int cnt_width(input int mod);
    return (mod > 2) ? $clog2(mod) : 1;
  endfunction

endpackage

// File: rtl/mod_counter_updown_if.sv
// mod_counter_updown_if: control/status bundle of one counter stage.
//   master modport - the block that drives the counter (enable, clear, load,
//                    load_value, up_dn, mode, start) and observes its outputs
//   slave modport  - the counter itself (drives q, tc, carry_out, done)
// Parameter MOD must match the counter it is connected to.
interface mod_counter_updown_if
  import mod_counter_pkg::*;
#(
  parameter int MOD = 13
);
  localparam int W = cnt_width(MOD);

  logic         enable;
  logic         clear;
  logic         load;
  logic [W-1:0] load_value;
  logic         up_dn;
  logic         mode;
  logic         start;
  logic [W-1:0] q;
  logic         tc;
  logic         carry_out;
  logic         done;

  modport master (
    output enable, clear, load, load_value, up_dn, mode, start,
    input  q, tc, carry_out, done
  );

  modport slave (
    input  enable, clear, load, load_value, up_dn, mode, start,
    output q, tc, carry_out, done
  );

endinterface

// File: rtl/mod_counter_next.sv
// mod_counter_next: combinational next-count and terminal-count logic.
//   q      in  W  current count (always 0..MOD-1)
//   up_dn  in  1  1 = up, 0 = down
//   q_next out W  count after one step, wrapping modulo MOD
//   tc     out 1  q is at the terminal value for the current direction
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int MOD = 13
) (
  input  logic [cnt_width(MOD)-1:0] q,
  input  logic                      up_dn,
  output logic [cnt_width(MOD)-1:0] q_next,
  output logic                      tc
);
  localparam int W = cnt_width(MOD);
  localparam logic [W-1:0] MAX_Q = W'(MOD - 1);
  localparam logic [W:0]   MOD_X = (W + 1)'(MOD);

  // One extra bit so q+1 at MOD-1 is seen as MOD rather than overflowing,
  // which matters when MOD is a power of two.
  logic [W:0] q_ext;
  logic [W:0] q_inc;

  assign q_ext = {1'b0, q};
  assign q_inc = q_ext + 1'b1;

  always_comb begin
    q_next = q;
    tc     = 1'b0;
    if (up_dn == DIR_UP) begin
      tc     = (q == MAX_Q);
      q_next = (q_inc >= MOD_X) ? '0 : q_inc[W-1:0];
    end else begin
      tc     = (q == '0);
      q_next = (q == '0) ? MAX_Q : (q - 1'b1);
    end
  end

endmodule

// File: rtl/mod_counter_updown.sv
// mod_counter_updown: modulus-MOD up/down counter with clear, clamped load,
// terminal count and a carry chain for cascading, plus an optional one-shot
// mode.
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-high reset
//   cnt    slave modport of mod_counter_updown_if:
//            enable, clear, load, load_value, up_dn, mode, start -> in
//            q (registered), tc (comb), carry_out (comb), done (registered)
// Build option: define MOD_COUNTER_ONESHOT_EN to build the one-shot FSM,
// start handling and done register. Without it mode and start are ignored,
// the counter always free-runs and done is tied low.
module mod_counter_updown
  import mod_counter_pkg::*;
#(
  parameter int MOD = 13
) (
  input logic                clk,
  input logic                reset,
  mod_counter_updown_if.slave cnt
);
  localparam int W = cnt_width(MOD);
  localparam logic [W-1:0] MAX_Q = W'(MOD - 1);

  logic [W-1:0] q_r;
  logic [W-1:0] q_next;
  logic         tc;
  logic [W-1:0] load_clamped;

  mod_counter_next #(.MOD(MOD)) u_next (
    .q      (q_r),
    .up_dn  (cnt.up_dn),
    .q_next (q_next),
    .tc     (tc)
  );

  // Out-of-range load values saturate to the top count.
  assign load_clamped = (cnt.load_value > MAX_Q) ? MAX_Q : cnt.load_value;

  assign cnt.q  = q_r;
  assign cnt.tc = tc;

`ifdef MOD_COUNTER_ONESHOT_EN

  state_t       state;
  logic         done_r;
  logic [W-1:0] preload;

  assign preload = (cnt.up_dn == DIR_UP) ? '0 : MAX_Q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r    <= '0;
      state  <= IDLE;
      done_r <= 1'b0;
    end else if (cnt.clear) begin
      q_r    <= '0;
      state  <= IDLE;
      done_r <= 1'b0;
    end else if (cnt.mode == MODE_WRAP) begin
      // Free-run: the FSM is parked so a later switch to one-shot starts clean.
      state  <= IDLE;
      done_r <= 1'b0;
      if (cnt.load)        q_r <= load_clamped;
      else if (cnt.enable) q_r <= q_next;
    end else if (cnt.load) begin
      q_r <= load_clamped;
    end else if (cnt.start) begin
      q_r    <= preload;
      state  <= RUN;
      done_r <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (cnt.enable) begin
            // Stop on the terminal value instead of wrapping.
            if (tc) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              q_r <= q_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // In one-shot mode the carry only fires from RUN, so a finished counter
  // sitting on its terminal value does not keep enabling the next stage.
  assign cnt.carry_out = cnt.enable & tc &
                         ((cnt.mode == MODE_WRAP) | (state == RUN));
  assign cnt.done      = done_r;

`else

  logic unused_ctrl;
  assign unused_ctrl = cnt.mode ^ cnt.start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= '0;
    end else if (cnt.clear) begin
      q_r <= '0;
    end else if (cnt.load) begin
      q_r <= load_clamped;
    end else if (cnt.enable) begin
      q_r <= q_next;
    end
  end

  assign cnt.carry_out = cnt.enable & tc;
  assign cnt.done      = 1'b0;

`endif

endmodule

// File: tb/tb_mod_counter_updown.sv
module tb_mod_counter_updown;
  import mod_counter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   pulses;

  always #5 clk = ~clk;

  mod_counter_updown_if #(.MOD(13)) if13 ();
  mod_counter_updown_if #(.MOD(10)) if10 ();
  mod_counter_updown_if #(.MOD(5))  if5  ();
  mod_counter_updown_if #(.MOD(10)) iflo ();
  mod_counter_updown_if #(.MOD(10)) ifhi ();

  mod_counter_updown #(.MOD(13)) u13 (.clk(clk), .reset(reset), .cnt(if13));
  mod_counter_updown #(.MOD(10)) u10 (.clk(clk), .reset(reset), .cnt(if10));
  mod_counter_updown #(.MOD(5))  u5  (.clk(clk), .reset(reset), .cnt(if5));
  mod_counter_updown #(.MOD(10)) ulo (.clk(clk), .reset(reset), .cnt(iflo));
  mod_counter_updown #(.MOD(10)) uhi (.clk(clk), .reset(reset), .cnt(ifhi));

  // Cascade: the upper stage counts on the lower stage's carry.
  assign ifhi.enable = iflo.carry_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    if13.enable = 0; if13.clear = 0; if13.load = 0; if13.load_value = '0;
    if13.up_dn = DIR_UP; if13.mode = MODE_WRAP; if13.start = 0;
    if10.enable = 0; if10.clear = 0; if10.load = 0; if10.load_value = '0;
    if10.up_dn = DIR_DOWN; if10.mode = MODE_WRAP; if10.start = 0;
    if5.enable = 0; if5.clear = 0; if5.load = 0; if5.load_value = '0;
    if5.up_dn = DIR_UP; if5.mode = MODE_WRAP; if5.start = 0;
    iflo.enable = 0; iflo.clear = 0; iflo.load = 0; iflo.load_value = '0;
    iflo.up_dn = DIR_UP; iflo.mode = MODE_WRAP; iflo.start = 0;
    ifhi.clear = 0; ifhi.load = 0; ifhi.load_value = '0;
    ifhi.up_dn = DIR_UP; ifhi.mode = MODE_WRAP; ifhi.start = 0;

    tick(); tick();
    check("rst_q13", if13.q, 0);
    check("rst_tc13_up", if13.tc, 0);
    check("rst_carry13", if13.carry_out, 0);
    check("rst_done13", if13.done, 0);
    check("rst_tc10_down", if10.tc, 1);
    reset = 1'b0;

    // Free-run up, MOD=13: 0..12 then wrap to 0.
    if13.enable = 1;
    #1;
    for (int i = 0; i < 14; i++) begin
      check("wrap13_q", if13.q, i % 13);
      check("wrap13_tc", if13.tc, (i % 13) == 12);
      check("wrap13_carry", if13.carry_out, (i % 13) == 12);
      tick();
    end
    if13.enable = 0;

    // Down from reset, MOD=10: first enabled edge gives 9.
    if10.enable = 1;
    #1;
    check("down10_tc_at0", if10.tc, 1);
    check("down10_carry_at0", if10.carry_out, 1);
    tick();
    check("down10_first", if10.q, 9);
    check("down10_tc_at9", if10.tc, 0);
    if10.enable = 0;

    // Load clamp, in-range load, tc re-evaluation on direction change.
    if13.load = 1; if13.load_value = 4'd15;
    tick();
    if13.load = 0;
    check("load_clamp", if13.q, 12);
    check("tc_at_max_up", if13.tc, 1);
    if13.up_dn = DIR_DOWN;
    #1;
    check("tc_dir_flip", if13.tc, 0);
    if13.up_dn = DIR_UP;
    if13.load = 1; if13.load_value = 4'd7;
    tick();
    check("load_inrange", if13.q, 7);
    if13.clear = 1; if13.load = 1; if13.load_value = 4'd5;
    tick();
    check("clear_beats_load", if13.q, 0);
    if13.load = 0; if13.enable = 1;
    tick();
    check("clear_beats_count", if13.q, 0);
    if13.clear = 0; if13.enable = 0;

`ifdef MOD_COUNTER_ONESHOT_EN
    // One-shot, MOD=5, up.
    if5.mode = MODE_ONESHOT; if5.enable = 1;
    tick();
    check("os_idle_hold", if5.q, 0);
    if5.load = 1; if5.load_value = 3'd2; if5.start = 1;
    tick();
    if5.load = 0; if5.start = 0;
    check("os_load_beats_start", if5.q, 2);
    tick();
    check("os_still_idle", if5.q, 2);
    if5.start = 1;
    tick();
    if5.start = 0;
    check("os_start_q", if5.q, 0);
    check("os_start_done", if5.done, 0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      check("os_run_q", if5.q, (k < 4) ? k : 4);
      check("os_run_done", if5.done, k >= 5);
      check("os_run_carry", if5.carry_out, k == 4);
      if (if5.carry_out) pulses++;
      tick();
    end
    check("os_pulse_count", pulses, 1);
    if5.mode = MODE_WRAP; if5.enable = 0;
    tick();
    check("os_mode0_done", if5.done, 0);
    check("os_mode0_q", if5.q, 4);
    if5.mode = MODE_ONESHOT; if5.start = 1;
    tick();
    if5.start = 0; if5.enable = 1;
    check("os_restart_q", if5.q, 0);
    tick(); tick(); tick();
    check("os_q3", if5.q, 3);
    #3 reset = 1'b1;
    #1;
    check("async_rst_q", if5.q, 0);
    check("async_rst_done", if5.done, 0);
    reset = 1'b0;
    tick();
    check("post_rst_idle", if5.q, 0);
    if5.start = 1;
    tick();
    if5.start = 0;
    tick();
    check("post_rst_count", if5.q, 1);
    if5.enable = 0;
`else
    // Without the one-shot build, mode and start are ignored.
    if5.mode = MODE_ONESHOT; if5.start = 1; if5.enable = 1;
    tick();
    check("noos_q1", if5.q, 1);
    check("noos_done", if5.done, 0);
    if5.start = 0;
    tick(); tick(); tick();
    check("noos_q4", if5.q, 4);
    check("noos_carry", if5.carry_out, 1);
    tick();
    check("noos_wrap", if5.q, 0);
    #3 reset = 1'b1;
    #1;
    check("async_rst_q", if5.q, 0);
    reset = 1'b0;
    if5.enable = 0;
`endif

    // Two cascaded MOD=10 stages: reset them, then 100 enables.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    iflo.enable = 1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      check("casc_lo", iflo.q, k % 10);
      check("casc_hi", ifhi.q, (k / 10) % 10);
    end
    iflo.enable = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
